output_drain: RTL

- Downstream stage of the output buffer (16 rows x 256 x 32-bit).
- On a start command, reads a run of rows out of the buffer one row at a time.
- Latches each row locally, then serializes it into BEAT_WORDS-wide beats on a valid/ready memory write stream with byte addresses.
- Frees the output buffer for the next MLU round while results drain to memory.

---
 rtl/output_drain.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/output_drain.sv
// output_drain: streams rows of the 16 x 256 x 32-bit output buffer to a
// valid/ready memory write port as BEAT_WORDS-wide beats with byte addresses.
// Each row is read once (REQ/WAIT/LOAD) and latched locally, so the buffer is
// free again while the row drains.
// Build option: define OUTPUT_DRAIN_RELU_EN to zero negative words as they are latched.
module output_drain #(
    parameter int BEAT_WORDS = 16,
    parameter int ADDR_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [3:0]               base_row,
    input  logic [4:0]               num_rows,
    input  logic [ADDR_W-1:0]        base_addr,
    output logic                     busy,
    output logic                     done,
    output logic [3:0]               ob_idx,
    output logic                     ob_read_en,
    input  logic [31:0]              ob_data [0:255],
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [32*BEAT_WORDS-1:0] mem_data,
    output logic                     mem_last
);
    localparam int BEATS = 256 / BEAT_WORDS;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_W-1:0] BEAT_STRIDE = ADDR_W'(4 * BEAT_WORDS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_LOAD = 3'd3,
        S_SEND = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;

    // run parameters captured at start
    logic [3:0]               r_base_row;
    logic [4:0]               r_num_rows;
    logic [ADDR_W-1:0]        r_base_addr;

    // position within the run
    logic [4:0]               r_row_cnt;
    logic [BCW-1:0]           r_beat_cnt;

    // local copy of the current row
    logic [255:0][31:0]       r_row;

    // registered outputs
    logic                     r_busy;
    logic                     r_done;
    logic                     r_ob_read_en;
    logic [3:0]               r_ob_idx;
    logic                     r_mem_valid;
    logic [ADDR_W-1:0]        r_mem_addr;
    logic [32*BEAT_WORDS-1:0] r_mem_data;
    logic                     r_mem_last;

    logic                     w_hs;
    logic                     w_last_beat;
    logic                     w_next_is_last_beat;
    logic                     w_last_row;
    logic [4:0]               w_num_clamped;
    logic [ADDR_W-1:0]        w_row_addr;
    logic [7:0]               w_next_base;
    logic [255:0][31:0]       w_loaded_row;
    logic [32*BEAT_WORDS-1:0] w_first_beat;
    logic [32*BEAT_WORDS-1:0] w_next_beat;

    // Word filter applied as a row is latched: negative words clamp to zero when enabled.
    function automatic logic [31:0] relu_word(input logic [31:0] word);
`ifdef OUTPUT_DRAIN_RELU_EN
        relu_word = word[31] ? 32'h0000_0000 : word;
`else
        relu_word = word;
`endif
    endfunction

    // Datapath helpers: handshake, end-of-row/run flags, row address and beat slices.
    always_comb begin
        w_hs                = r_mem_valid & mem_ready;
        w_last_beat         = (32'(r_beat_cnt) == 32'(BEATS - 1));
        w_next_is_last_beat = ((32'(r_beat_cnt) + 32'd1) == 32'(BEATS - 1));
        w_last_row          = (r_row_cnt == (r_num_rows - 5'd1));
        w_num_clamped       = (num_rows > 5'd16) ? 5'd16 : num_rows;
        w_row_addr          = r_base_addr + (ADDR_W'(r_row_cnt) << 4'd10);
        w_next_base         = 8'((32'(r_beat_cnt) + 32'd1) * 32'(BEAT_WORDS));
        w_loaded_row        = '0;
        w_first_beat        = '0;
        w_next_beat         = '0;
        for (int j = 0; j < 256; j++) begin
            w_loaded_row[8'(j)] = relu_word(ob_data[j]);
        end
        for (int k = 0; k < BEAT_WORDS; k++) begin
            w_first_beat[32*k +: 32] = w_loaded_row[8'(k)];
            w_next_beat[32*k +: 32]  = r_row[w_next_base + 8'(k)];
        end
    end

    // Next-state logic of the drain sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (num_rows == 5'd0) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_REQ;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_REQ:  w_next_state = S_WAIT;
            S_WAIT: w_next_state = S_LOAD;
            S_LOAD: w_next_state = S_SEND;
            S_SEND: begin
                if (w_hs && w_last_beat) begin
                    if (w_last_row) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_REQ;
                    end
                end else begin
                    w_next_state = S_SEND;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Row latch: captures the whole buffer row on the way out of LOAD.
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD) begin
            r_row <= w_loaded_row;
        end
    end

    // Run bookkeeping and registered outputs; strobes follow the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_base_row   <= 4'd0;
            r_num_rows   <= 5'd0;
            r_base_addr  <= '0;
            r_row_cnt    <= 5'd0;
            r_beat_cnt   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ob_read_en <= 1'b0;
            r_ob_idx     <= 4'd0;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_mem_last   <= 1'b0;
        end else begin
            r_busy       <= (w_next_state == S_REQ) || (w_next_state == S_WAIT) ||
                            (w_next_state == S_LOAD) || (w_next_state == S_SEND);
            r_done       <= (w_next_state == S_DONE);
            r_ob_read_en <= (w_next_state == S_REQ);
            case (r_state)
                S_IDLE: begin
                    if (start && (num_rows != 5'd0)) begin
                        r_base_row  <= base_row;
                        r_num_rows  <= w_num_clamped;
                        r_base_addr <= base_addr;
                        r_row_cnt   <= 5'd0;
                        r_ob_idx    <= base_row;
                    end
                end
                S_LOAD: begin
                    r_beat_cnt  <= '0;
                    r_mem_valid <= 1'b1;
                    r_mem_data  <= w_first_beat;
                    r_mem_addr  <= w_row_addr;
                    r_mem_last  <= (BEATS == 1) && w_last_row;
                end
                S_SEND: begin
                    if (w_hs) begin
                        if (!w_last_beat) begin
                            r_beat_cnt <= r_beat_cnt + BCW'(1'b1);
                            r_mem_data <= w_next_beat;
                            r_mem_addr <= r_mem_addr + BEAT_STRIDE;
                            r_mem_last <= w_next_is_last_beat && w_last_row;
                        end else begin
                            r_mem_valid <= 1'b0;
                            r_mem_last  <= 1'b0;
                            r_beat_cnt  <= '0;
                            if (!w_last_row) begin
                                r_row_cnt <= r_row_cnt + 5'd1;
                                // row index wraps 15 -> 0 through 4-bit arithmetic
                                r_ob_idx  <= r_base_row + r_row_cnt[3:0] + 4'd1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign ob_idx     = r_ob_idx;
    assign ob_read_en = r_ob_read_en;
    assign mem_valid  = r_mem_valid;
    assign mem_addr   = r_mem_addr;
    assign mem_data   = r_mem_data;
    assign mem_last   = r_mem_last;

endmodule
